// File: rtl/prog_loader.sv
// Byte-stream program loader: frames sync/count/words[/checksum] into program-memory writes
// and holds the core in reset until an image is accepted. Optional checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int         DATA_SIZE = 6,
    parameter int         ADDR_SIZE = 5,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 restart,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    output logic                 cpu_rstn,
    output logic                 done,
    output logic                 error
);

    localparam int CNT_W     = ADDR_SIZE + 1;
    localparam int MAX_WORDS = 1 << ADDR_SIZE;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_SYNC, S_COUNT, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
`else
    typedef enum logic [2:0] {S_SYNC, S_COUNT, S_DATA, S_DONE, S_ERROR} state_t;
`endif

    state_t               r_state, w_next_state;
    logic [CNT_W-1:0]     r_count, w_count_nx;
    logic [CNT_W-1:0]     r_idx, w_idx_nx, w_idx_inc;
    logic                 r_in_ready, r_mem_we, r_cpu_rstn, r_done, r_error;
    logic [ADDR_SIZE-1:0] r_mem_addr, w_addr_nx;
    logic [DATA_SIZE-1:0] r_mem_wdata, w_wdata_nx;
    logic                 w_we_nx;
    logic                 w_accept;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]           r_sum, w_sum_nx;
`endif

    assign w_accept  = in_valid & r_in_ready;
    assign w_idx_inc = r_idx + CNT_W'(1);

    always_comb begin
        w_next_state = r_state;
        w_count_nx   = r_count;
        w_idx_nx     = r_idx;
        w_we_nx      = 1'b0;
        w_addr_nx    = r_mem_addr;
        w_wdata_nx   = r_mem_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
        w_sum_nx     = r_sum;
`endif
        case (r_state)
            S_SYNC: begin
                if (w_accept && in_data == SYNC_BYTE) w_next_state = S_COUNT;
            end
            S_COUNT: begin
                if (w_accept) begin
                    if (in_data == 8'd0 || int'(in_data) > MAX_WORDS) begin
                        w_next_state = S_ERROR;
                    end else begin
                        w_count_nx   = CNT_W'(in_data);
                        w_idx_nx     = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        w_sum_nx     = 8'd0;
`endif
                        w_next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    // Bits above the word width must be clear; a dirty byte is never written.
                    if ((in_data >> DATA_SIZE) != 8'd0) begin
                        w_next_state = S_ERROR;
                    end else begin
                        w_we_nx    = 1'b1;
                        w_addr_nx  = r_idx[ADDR_SIZE-1:0];
                        w_wdata_nx = in_data[DATA_SIZE-1:0];
                        w_idx_nx   = w_idx_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
                        w_sum_nx   = r_sum + in_data;
                        if (w_idx_inc == r_count) w_next_state = S_CSUM;
`else
                        if (w_idx_inc == r_count) w_next_state = S_DONE;
`endif
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_accept) w_next_state = (in_data == r_sum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (restart) w_next_state = S_SYNC;
            end
            default: w_next_state = S_SYNC;
        endcase
    end

    // Flags are registered from the next state so they move one edge after the causing byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_SYNC;
            r_count     <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rstn  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum       <= 8'd0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_count     <= w_count_nx;
            r_idx       <= w_idx_nx;
            r_in_ready  <= (w_next_state != S_DONE) && (w_next_state != S_ERROR);
            r_mem_we    <= w_we_nx;
            r_mem_addr  <= w_addr_nx;
            r_mem_wdata <= w_wdata_nx;
            r_cpu_rstn  <= (w_next_state == S_DONE);
            r_done      <= (w_next_state == S_DONE);
            r_error     <= (w_next_state == S_ERROR);
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum       <= w_sum_nx;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rstn  = r_cpu_rstn;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; adapts frames to whether PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;
    localparam int DS = 6;
    localparam int AS = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          restart = 1'b0;
    logic          in_ready, mem_we, cpu_rstn, done, error;
    logic [AS-1:0] mem_addr;
    logic [DS-1:0] mem_wdata;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0]    tx_q[$];
    logic [AS-1:0] wr_addr[$];
    logic [DS-1:0] wr_data[$];
    int            wr_cyc[$];

    prog_loader #(.DATA_SIZE(DS), .ADDR_SIZE(AS), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rstn(cpu_rstn), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we === 1'b1) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
        wr_cyc.push_back(cyc);
    end

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waits = 0;
        @(negedge clk);
        in_data = b; in_valid = 1'b1;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk); waits++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL send_byte_timeout byte=%02h in_ready=%b required 1", b, in_ready);
        end else @(posedge clk);
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send_byte(tx_q[i]);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic pulse_restart(input logic with_byte);
        @(negedge clk);
        restart = 1'b1;
        if (with_byte) begin in_valid = 1'b1; in_data = 8'hA5; end
        @(negedge clk);
        restart = 1'b0; in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if ({in_ready, mem_we, cpu_rstn, done, error} !== 5'b0) begin n_bad++;
            $display("FAIL reset_flags got rdy/we/crst/done/err=%b required 00000", {in_ready, mem_we, cpu_rstn, done, error}); end
        n_vec++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_bad++;
            $display("FAIL reset_bus got addr=%h wdata=%h required 0/0", mem_addr, mem_wdata); end
        rstn = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_bad++;
            $display("FAIL reset_release_ready got %b required 0 before first edge", in_ready); end
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_bad++;
            $display("FAIL ready_after_reset got %b required 1", in_ready); end
    endtask

    task automatic test_good_frame();
        logic [AS-1:0] ea[3] = '{5'd0, 5'd1, 5'd2};
        logic [DS-1:0] ed[3] = '{6'h05, 6'h2A, 6'h3F};
        clear_log();
        tx_q = '{8'hA5, 8'h03, 8'h05, 8'h2A, 8'h3F};
`ifdef PROG_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h6E);
`endif
        send_q();
        n_vec++; if (wr_addr.size() != 3) begin n_bad++;
            $display("FAIL good_write_count got %0d required 3", wr_addr.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (i >= wr_addr.size() || wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin n_bad++;
                $display("FAIL good_write%0d got (%h,%h) required (%h,%h)", i,
                         (i < wr_addr.size()) ? wr_addr[i] : '1, (i < wr_data.size()) ? wr_data[i] : '1, ea[i], ed[i]); end
        end
        n_vec++; if (wr_cyc.size() != 3 || wr_cyc[1] - wr_cyc[0] != 1 || wr_cyc[2] - wr_cyc[1] != 1) begin n_bad++;
            $display("FAIL good_consecutive writes not on consecutive cycles (count %0d)", wr_cyc.size()); end
        n_vec++; if ({done, cpu_rstn, error, in_ready} !== 4'b1100) begin n_bad++;
            $display("FAIL good_flags got done/crst/err/rdy=%b required 1100", {done, cpu_rstn, error, in_ready}); end
        pulse_restart(1'b0);
        n_vec++; if ({done, cpu_rstn, error, in_ready} !== 4'b0001) begin n_bad++;
            $display("FAIL restart_from_done got done/crst/err/rdy=%b required 0001", {done, cpu_rstn, error, in_ready}); end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_bad_csum();
        clear_log();
        tx_q = '{8'hA5, 8'h03, 8'h05, 8'h2A, 8'h3F, 8'h6F};
        send_q();
        n_vec++; if (wr_addr.size() != 3) begin n_bad++;
            $display("FAIL csum_write_count got %0d required 3", wr_addr.size()); end
        n_vec++; if ({error, cpu_rstn, in_ready, done} !== 4'b1000) begin n_bad++;
            $display("FAIL csum_flags got err/crst/rdy/done=%b required 1000", {error, cpu_rstn, in_ready, done}); end
        pulse_restart(1'b0);
        n_vec++; if ({error, done, cpu_rstn, in_ready} !== 4'b0001) begin n_bad++;
            $display("FAIL csum_restart got err/done/crst/rdy=%b required 0001", {error, done, cpu_rstn, in_ready}); end
    endtask
`endif

    task automatic test_bad_data();
        clear_log();
        tx_q = '{8'hA5, 8'h02, 8'h05, 8'h45};
        send_q();
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (wr_addr.size() != 1 || wr_addr[0] !== 5'd0 || wr_data[0] !== 6'h05) begin n_bad++;
            $display("FAIL bad_data_writes got count %0d required single (0,05)", wr_addr.size()); end
        n_vec++; if ({error, cpu_rstn, done} !== 3'b100) begin n_bad++;
            $display("FAIL bad_data_flags got err/crst/done=%b required 100", {error, cpu_rstn, done}); end
        // Restart collides with a valid byte: restart must win and the byte must be dropped.
        pulse_restart(1'b1);
        n_vec++; if ({error, in_ready} !== 2'b01) begin n_bad++;
            $display("FAIL restart_priority got err/rdy=%b required 01", {error, in_ready}); end
    endtask

    task automatic test_count_bounds();
        clear_log();
        tx_q = '{8'hA5, 8'h00};
        send_q();
        n_vec++; if (error !== 1'b1 || wr_addr.size() != 0) begin n_bad++;
            $display("FAIL count_zero got err=%b writes=%0d required 1/0", error, wr_addr.size()); end
        pulse_restart(1'b0);
        tx_q = '{8'hA5, 8'h21};
        send_q();
        n_vec++; if (error !== 1'b1 || wr_addr.size() != 0) begin n_bad++;
            $display("FAIL count_33 got err=%b writes=%0d required 1/0", error, wr_addr.size()); end
        pulse_restart(1'b0);
        tx_q = '{8'hA5, 8'h20};
        for (int i = 0; i < 32; i++) tx_q.push_back(8'(i));
`ifdef PROG_LOADER_CHECKSUM_EN
        tx_q.push_back(8'hF0);
`endif
        send_q();
        n_vec++; if (wr_addr.size() != 32) begin n_bad++;
            $display("FAIL full_write_count got %0d required 32", wr_addr.size()); end
        n_vec++; if (wr_addr.size() != 32 || wr_addr[31] !== 5'h1F || wr_data[31] !== 6'h1F || wr_addr[0] !== 5'h00) begin n_bad++;
            $display("FAIL full_last_write wrong first/last address or data (count %0d)", wr_addr.size()); end
        n_vec++; if ({done, cpu_rstn, error} !== 3'b110) begin n_bad++;
            $display("FAIL full_flags got done/crst/err=%b required 110", {done, cpu_rstn, error}); end
        pulse_restart(1'b0);
    endtask

    task automatic test_sync_hunt();
        clear_log();
        tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h07};
`ifdef PROG_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h07);
`endif
        send_q();
        n_vec++; if (wr_addr.size() != 1 || wr_addr[0] !== 5'd0 || wr_data[0] !== 6'h07) begin n_bad++;
            $display("FAIL sync_hunt_write got count %0d required single (0,07)", wr_addr.size()); end
        n_vec++; if ({done, cpu_rstn, error} !== 3'b110) begin n_bad++;
            $display("FAIL sync_hunt_flags got done/crst/err=%b required 110", {done, cpu_rstn, error}); end
        pulse_restart(1'b0);
    endtask

    task automatic test_reset_midframe();
        clear_log();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h05); send_byte(8'h2A);
        @(negedge clk);
        in_valid = 1'b0;
        #1 rstn = 1'b0;
        #1;
        n_vec++; if ({in_ready, mem_we, cpu_rstn, done, error} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin n_bad++;
            $display("FAIL midframe_reset got rdy/we/crst/done/err=%b addr=%h wdata=%h required all 0",
                     {in_ready, mem_we, cpu_rstn, done, error}, mem_addr, mem_wdata); end
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (wr_addr.size() != 2) begin n_bad++;
            $display("FAIL midframe_writes got %0d required 2", wr_addr.size()); end
        rstn = 1'b1;
        @(negedge clk);
        clear_log();
        tx_q = '{8'hA5, 8'h02, 8'h11, 8'h22};
`ifdef PROG_LOADER_CHECKSUM_EN
        tx_q.push_back(8'h33);
`endif
        send_q();
        n_vec++; if (wr_addr.size() != 2 || wr_addr[0] !== 5'd0 || wr_data[0] !== 6'h11 ||
                     wr_addr[1] !== 5'd1 || wr_data[1] !== 6'h22) begin n_bad++;
            $display("FAIL reload_writes got count %0d required (0,11),(1,22)", wr_addr.size()); end
        n_vec++; if ({done, cpu_rstn, error} !== 3'b110) begin n_bad++;
            $display("FAIL reload_flags got done/crst/err=%b required 110", {done, cpu_rstn, error}); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_good_frame();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_bad_csum();
`endif
        test_bad_data();
        test_count_bounds();
        test_sync_hunt();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
